// File: rtl/rf_write_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// rf_write_arbiter_pkg
//   Definitions shared by the register-file write arbiter and its scoreboard.
//   - arb_state_t  : arbitration state (ST_NORMAL / ST_FORCE)
//   - REG_ZERO     : hard-wired zero register, which is never written or tracked
//   - DEF_MAX_WAIT : default count of blocked LLU cycles before a forced slot
// ----------------------------------------------------------------------------
package rf_write_arbiter_pkg;

    typedef enum logic {
        ST_NORMAL = 1'b0,   // pipeline has priority on the write port
        ST_FORCE  = 1'b1    // one-cycle pipeline stall, the write port belongs to the LLU
    } arb_state_t;

    localparam int REG_ZERO     = 0;
    localparam int DEF_MAX_WAIT = 4;

endpackage

// File: rtl/rf_scoreboard.sv
// ----------------------------------------------------------------------------
// rf_scoreboard
//   Pending-write scoreboard for long-latency-unit destinations. Each bit
//   marks a register that has an LLU result still in flight.
//
// Ports
//   clk, reset            : clock, asynchronous active-high reset
//   i_set_en / i_set_rd   : an LLU op was issued to i_set_rd (set wins over clear)
//   i_clr_en / i_clr_rd   : an LLU result was written back to i_clr_rd
//   i_chk_rs1/rs2/rd      : decode-stage register numbers to look up
//   o_hz_rs1/rs2/rd       : looked-up register has a pending LLU write
//                           (registered state only, always 0 for register 0)
// ----------------------------------------------------------------------------
module rf_scoreboard
    import rf_write_arbiter_pkg::*;
#(
    parameter int N = 5,
    parameter int L = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_set_en,
    input  logic [N-1:0] i_set_rd,
    input  logic         i_clr_en,
    input  logic [N-1:0] i_clr_rd,
    input  logic [N-1:0] i_chk_rs1,
    input  logic [N-1:0] i_chk_rs2,
    input  logic [N-1:0] i_chk_rd,
    output logic         o_hz_rs1,
    output logic         o_hz_rs2,
    output logic         o_hz_rd
);

    logic [L-1:0] r_pending;
    logic [L-1:0] w_pending_next;

    // The set is applied after the clear, so issuing a new op to a register
    // whose previous result is retiring in the same cycle keeps it pending.
    always_comb begin
        // NOTE: the default assignment first means every path drives w_pending_next, so no latch is inferred.
        // NOTE: blocking '=' in combinational logic lets the later set override the earlier clear.
        w_pending_next = r_pending;
        if (i_clr_en && (int'(i_clr_rd) < L))
            w_pending_next[i_clr_rd] = 1'b0;
        if (i_set_en && (int'(i_set_rd) != REG_ZERO) && (int'(i_set_rd) < L))
            w_pending_next[i_set_rd] = 1'b1;
    end

    // NOTE: this is a flop vector, not a RAM, so it is reset; hazards must read 0 right out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_pending <= '0;
        else
            r_pending <= w_pending_next;
    end

    function automatic logic f_lookup(input logic [L-1:0] pend, input logic [N-1:0] rd);
        if ((int'(rd) == REG_ZERO) || (int'(rd) >= L))
            return 1'b0;
        return pend[rd];
    endfunction

    assign o_hz_rs1 = f_lookup(r_pending, i_chk_rs1);
    assign o_hz_rs2 = f_lookup(r_pending, i_chk_rs2);
    assign o_hz_rd  = f_lookup(r_pending, i_chk_rd);

endmodule

// File: rtl/rf_write_arbiter.sv
// ----------------------------------------------------------------------------
// rf_write_arbiter
//   Shares the register file's single write port between the pipeline
//   writeback stage (fixed priority) and a long-latency unit (LLU). If the
//   LLU is blocked for MAX_WAIT consecutive cycles, the arbiter stalls the
//   pipeline for exactly one cycle and gives that slot to the LLU. A
//   scoreboard of in-flight LLU destinations drives decode-stage hazard
//   flags.
//
// Ports
//   clk, reset                 : clock (rising edge), async active-high reset
//   pipe_we/pipe_rd/pipe_wd    : pipeline writeback request
//   pipe_stall                 : registered pipeline freeze (high in ST_FORCE)
//   llu_valid/llu_rd/llu_wd    : LLU result request
//   llu_ready                  : LLU result accepted this cycle (combinational)
//   alloc_valid/alloc_rd       : LLU op issued, destination becomes pending
//   chk_rs1/chk_rs2/chk_rd     : decode-stage register numbers
//   hz_rs1/hz_rs2/hz_rd        : register has a pending LLU write
//   rf_we/rf_a3/rf_wd3         : register-file write port (sampled on falling edge)
//
// Optional feature (macro ARB_STATS_EN)
//   stat_force_cnt [15:0]      : saturating count of NORMAL->FORCE transitions
// ----------------------------------------------------------------------------
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int N        = 5,
    parameter int M        = 32,
    parameter int L        = 32,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pipe_we,
    input  logic [N-1:0] pipe_rd,
    input  logic [M-1:0] pipe_wd,
    output logic         pipe_stall,
    input  logic         llu_valid,
    input  logic [N-1:0] llu_rd,
    input  logic [M-1:0] llu_wd,
    output logic         llu_ready,
    input  logic         alloc_valid,
    input  logic [N-1:0] alloc_rd,
    input  logic [N-1:0] chk_rs1,
    input  logic [N-1:0] chk_rs2,
    input  logic [N-1:0] chk_rd,
    output logic         hz_rs1,
    output logic         hz_rs2,
    output logic         hz_rd,
    output logic         rf_we,
    output logic [N-1:0] rf_a3,
    output logic [M-1:0] rf_wd3
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]  stat_force_cnt
`endif
);

    // The wait counter only has to reach MAX_WAIT-1; entering ST_FORCE clears it.
    localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

    arb_state_t       r_state;
    arb_state_t       w_state_next;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_next;
    logic             w_sel_llu;    // write port carries the LLU request
    logic             w_wr_req;     // selected source has a valid write this cycle
    logic             w_llu_grant;  // LLU handshake, before reset gating
    logic [N-1:0]     w_sel_rd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_NORMAL;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        w_sel_llu       = 1'b0;
        w_wr_req        = 1'b0;
        w_llu_grant     = 1'b0;
        unique case (r_state)
            ST_NORMAL: begin
                if (pipe_we) begin
                    w_wr_req = 1'b1;
                end else if (llu_valid) begin
                    w_sel_llu   = 1'b1;
                    w_wr_req    = 1'b1;
                    w_llu_grant = 1'b1;
                end
                // The LLU is blocked only while it is valid and the pipeline holds the port.
                if (llu_valid && !w_llu_grant) begin
                    if (r_wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
                        w_state_next    = ST_FORCE;
                        w_wait_cnt_next = '0;
                    end else begin
                        w_wait_cnt_next = r_wait_cnt + 1'b1;
                    end
                end else begin
                    w_wait_cnt_next = '0;
                end
            end
            ST_FORCE: begin
                // pipe_we is ignored: the stalled pipeline re-presents its write later.
                // A missing LLU result here still ends the slot, with no write.
                w_sel_llu       = 1'b1;
                w_wr_req        = llu_valid;
                w_llu_grant     = llu_valid;
                w_state_next    = ST_NORMAL;
                w_wait_cnt_next = '0;
            end
            default: begin
                w_state_next    = ST_NORMAL;
                w_wait_cnt_next = '0;
            end
        endcase
    end

    assign w_sel_rd = w_sel_llu ? llu_rd : pipe_rd;

    // Grants are gated by reset so the write port and handshake drop the moment
    // reset asserts, even though they are combinational from the inputs.
    // A write to register zero is suppressed, but the handshake still completes.
    assign rf_we      = !reset && w_wr_req && (w_sel_rd != N'(REG_ZERO));
    assign rf_a3      = w_sel_rd;
    assign rf_wd3     = w_sel_llu ? llu_wd : pipe_wd;
    assign llu_ready  = !reset && w_llu_grant;
    assign pipe_stall = (r_state == ST_FORCE);

    rf_scoreboard #(
        .N (N),
        .L (L)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .i_set_en  (alloc_valid),
        .i_set_rd  (alloc_rd),
        .i_clr_en  (llu_ready),
        .i_clr_rd  (llu_rd),
        .i_chk_rs1 (chk_rs1),
        .i_chk_rs2 (chk_rs2),
        .i_chk_rd  (chk_rd),
        .o_hz_rs1  (hz_rs1),
        .o_hz_rs2  (hz_rs2),
        .o_hz_rd   (hz_rd)
    );

`ifdef ARB_STATS_EN
    logic [15:0] r_stat_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_stat_cnt <= '0;
        else if ((r_state == ST_NORMAL) && (w_state_next == ST_FORCE) && (r_stat_cnt != 16'hFFFF))
            r_stat_cnt <= r_stat_cnt + 16'd1;
    end

    assign stat_force_cnt = r_stat_cnt;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rf_write_arbiter
//   Directed and randomized stimulus for rf_write_arbiter, compared against a
//   behavioural model of the arbitration and scoreboard rules. Honours the
//   ARB_STATS_EN macro when it is defined.
// ----------------------------------------------------------------------------
module tb_rf_write_arbiter;

    localparam int N        = 5;
    localparam int M        = 32;
    localparam int L        = 32;
    localparam int MAX_WAIT = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         pipe_we;
    logic [N-1:0] pipe_rd;
    logic [M-1:0] pipe_wd;
    logic         pipe_stall;
    logic         llu_valid;
    logic [N-1:0] llu_rd;
    logic [M-1:0] llu_wd;
    logic         llu_ready;
    logic         alloc_valid;
    logic [N-1:0] alloc_rd;
    logic [N-1:0] chk_rs1, chk_rs2, chk_rd;
    logic         hz_rs1, hz_rs2, hz_rd;
    logic         rf_we;
    logic [N-1:0] rf_a3;
    logic [M-1:0] rf_wd3;
`ifdef ARB_STATS_EN
    logic [15:0]  stat_force_cnt;
`endif

    always #5 clk = ~clk;

    rf_write_arbiter #(
        .N        (N),
        .M        (M),
        .L        (L),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pipe_we     (pipe_we),
        .pipe_rd     (pipe_rd),
        .pipe_wd     (pipe_wd),
        .pipe_stall  (pipe_stall),
        .llu_valid   (llu_valid),
        .llu_rd      (llu_rd),
        .llu_wd      (llu_wd),
        .llu_ready   (llu_ready),
        .alloc_valid (alloc_valid),
        .alloc_rd    (alloc_rd),
        .chk_rs1     (chk_rs1),
        .chk_rs2     (chk_rs2),
        .chk_rd      (chk_rd),
        .hz_rs1      (hz_rs1),
        .hz_rs2      (hz_rs2),
        .hz_rd       (hz_rd),
        .rf_we       (rf_we),
        .rf_a3       (rf_a3),
        .rf_wd3      (rf_wd3)
`ifdef ARB_STATS_EN
        ,
        .stat_force_cnt (stat_force_cnt)
`endif
    );

    int n_checks = 0;
    int n_bad    = 0;

    // Behavioural model: pending registers, whether the coming cycle is a
    // forced LLU slot, and how many consecutive cycles the LLU has lost.
    bit m_pend [L];
    bit m_stall;
    int m_lost;
    int m_forces;

    // Outputs observed in the most recent cycle, for directed follow-up checks.
    logic         last_we, last_ready, last_stall, last_hz1, last_hzd;
    logic [N-1:0] last_a3;
    logic [M-1:0] last_wd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_stall  = 1'b0;
        m_lost   = 0;
        m_forces = 0;
    endtask

    // One clock cycle: drive at posedge+1, sample at posedge+4, advance the
    // model across the next rising edge.
    task automatic cycle(input logic pw, input logic [N-1:0] prd, input logic [M-1:0] pwd,
                         input logic lv, input logic [N-1:0] lrd, input logic [M-1:0] lwd,
                         input logic av, input logic [N-1:0] ard,
                         input logic [N-1:0] c1, input logic [N-1:0] c2, input logic [N-1:0] cd);
        bit pipe_wins, llu_wins, exp_we;
        pipe_we = pw;  pipe_rd = prd; pipe_wd = pwd;
        llu_valid = lv; llu_rd = lrd; llu_wd = lwd;
        alloc_valid = av; alloc_rd = ard;
        chk_rs1 = c1; chk_rs2 = c2; chk_rd = cd;
        #3;
        pipe_wins = !m_stall && pw;
        llu_wins  = lv && (m_stall || !pw);
        exp_we    = (pipe_wins && prd != 0) || (llu_wins && lrd != 0);

        last_we = rf_we; last_ready = llu_ready; last_stall = pipe_stall;
        last_a3 = rf_a3; last_wd = rf_wd3; last_hz1 = hz_rs1; last_hzd = hz_rd;

        check("stall", 32'(pipe_stall), 32'(m_stall));
        check("ready", 32'(llu_ready), 32'(llu_wins));
        check("we",    32'(rf_we), 32'(exp_we));
        if (exp_we) begin
            check("a3", 32'(rf_a3), pipe_wins ? 32'(prd) : 32'(lrd));
            check("wd", rf_wd3, pipe_wins ? pwd : lwd);
        end
        check("hz_rs1", 32'(hz_rs1), 32'(m_pend[c1]));
        check("hz_rs2", 32'(hz_rs2), 32'(m_pend[c2]));
        check("hz_rd",  32'(hz_rd),  32'(m_pend[cd]));
`ifdef ARB_STATS_EN
        check("stat", 32'(stat_force_cnt), 32'(m_forces));
`endif

        // The forced slot lasts one cycle; otherwise count consecutive losses.
        if (m_stall) begin
            m_stall = 1'b0;
            m_lost  = 0;
        end else if (lv && !llu_wins) begin
            m_lost++;
            if (m_lost == MAX_WAIT) begin
                m_stall = 1'b1;
                m_lost  = 0;
                if (m_forces < 16'hFFFF) m_forces++;
            end
        end else begin
            m_lost = 0;
        end
        if (llu_wins) m_pend[lrd] = 1'b0;
        if (av && ard != 0) m_pend[ard] = 1'b1;

        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
    endtask

    initial begin
        reset = 1'b1;
        pipe_we = 1'b1; pipe_rd = 5'd5; pipe_wd = 32'h11;
        llu_valid = 1'b1; llu_rd = 5'd9; llu_wd = 32'hAB;
        alloc_valid = 1'b0; alloc_rd = '0;
        chk_rs1 = 5'd9; chk_rs2 = 5'd5; chk_rd = 5'd1;
        model_reset();

        // Reset state: every request is active, yet nothing may be granted.
        #1;
        check("rst_stall", 32'(pipe_stall), 32'd0);
        check("rst_we",    32'(rf_we), 32'd0);
        check("rst_ready", 32'(llu_ready), 32'd0);
        check("rst_hz",    32'({hz_rs1, hz_rs2, hz_rd}), 32'd0);
`ifdef ARB_STATS_EN
        check("rst_stat",  32'(stat_force_cnt), 32'd0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Pipeline write wins on its own.
        cycle(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        check("tp_pipe_a3", 32'(last_a3), 32'd5);
        check("tp_pipe_wd", last_wd, 32'h11);
        check("tp_pipe_ready", 32'(last_ready), 32'd0);

        // LLU grant clears its pending bit, visible the following cycle.
        cycle(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 5'd9, 5'd9, 5'd0, 5'd0);
        cycle(1'b0, 5'd0, '0, 1'b1, 5'd9, 32'hAB, 1'b0, 5'd0, 5'd9, 5'd0, 5'd0);
        check("tp_llu_ready", 32'(last_ready), 32'd1);
        check("tp_llu_a3", 32'(last_a3), 32'd9);
        check("tp_llu_wd", last_wd, 32'hAB);
        check("tp_hz_before", 32'(last_hz1), 32'd1);
        idle();
        cycle(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd9, 5'd0, 5'd0);
        check("tp_hz_after", 32'(last_hz1), 32'd0);

        // Starvation: four blocked cycles, then a single forced slot.
        for (int k = 0; k < MAX_WAIT; k++) begin
            cycle(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
            check("starve_blocked", 32'({last_stall, last_ready}), 32'd0);
        end
        cycle(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        check("starve_stall", 32'(last_stall), 32'd1);
        check("starve_a3", 32'(last_a3), 32'd4);
        check("starve_ready", 32'(last_ready), 32'd1);
        cycle(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        check("starve_release", 32'(last_stall), 32'd0);
`ifdef ARB_STATS_EN
        check("starve_stat", 32'(stat_force_cnt), 32'd1);
`endif

        // Set and clear of the same register: set wins.
        cycle(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 5'd7, 5'd0, 5'd0, 5'd0);
        cycle(1'b0, 5'd0, '0, 1'b1, 5'd7, 32'h77, 1'b1, 5'd7, 5'd0, 5'd0, 5'd7);
        cycle(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 5'd0, 5'd0, 5'd0, 5'd7);
        check("setwins_hz", 32'(last_hzd), 32'd1);
        cycle(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        check("alloc0_hz", 32'(last_hzd), 32'd0);

        // LLU result to register zero: accepted but not written.
        cycle(1'b0, 5'd0, '0, 1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        check("x0_ready", 32'(last_ready), 32'd1);
        check("x0_we", 32'(last_we), 32'd0);

        // Reset arriving during a forced slot.
        idle();
        for (int k = 0; k < MAX_WAIT; k++)
            cycle(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 5'd7, 5'd7, 5'd7);
        pipe_we = 1'b1; llu_valid = 1'b1; llu_rd = 5'd4;
        chk_rs1 = 5'd7; chk_rs2 = 5'd7; chk_rd = 5'd7;
        #2;
        check("rf_pre_stall", 32'(pipe_stall), 32'd1);
        check("rf_pre_hz", 32'(hz_rd), 32'd1);
        reset = 1'b1;
        #1;
        check("rf_stall", 32'(pipe_stall), 32'd0);
        check("rf_we", 32'(rf_we), 32'd0);
        check("rf_ready", 32'(llu_ready), 32'd0);
        check("rf_hz", 32'({hz_rs1, hz_rs2, hz_rd}), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd7, 5'd7, 5'd7);

        // Randomized traffic, with bursts of pipeline pressure to provoke starvation.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), 32'($urandom),
                  1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), 32'($urandom),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register file's single write port (we/a3/wd3) between the pipeline writeback stage and a long-latency unit (LLU, e.g. mul/div).
- Pipeline has fixed priority. A wait counter bounds LLU starvation by forcing a one-slot pipeline stall.
- Holds a pending-write scoreboard for LLU destinations and reports source/destination hazards to the decode stage.
- Sits between writeback/LLU and the register file.

Parameters:
N, 5, register address width
M, 32, data width
L, 32, number of architectural registers (scoreboard depth)
MAX_WAIT, 4, consecutive blocked LLU cycles before a forced slot (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
pipe_we  in  1  pipeline writeback valid
pipe_rd  in  N  pipeline destination
pipe_wd  in  M  pipeline write data
pipe_stall  out  1  freeze pipeline (registered)
llu_valid  in  1  LLU result valid
llu_rd  in  N  LLU destination
llu_wd  in  M  LLU result
llu_ready  out  1  LLU result accepted this cycle
alloc_valid  in  1  LLU op issued
alloc_rd  in  N  destination of issued LLU op
chk_rs1, chk_rs2, chk_rd  in  N  decode-stage register numbers
hz_rs1, hz_rs2, hz_rd  out  1  register is pending an LLU write
rf_we  out  1  to register file we
rf_a3  out  N  to register file a3
rf_wd3  out  M  to register file wd3

Behaviour:
- Reset (async, immediate):
  - state=NORMAL, wait_cnt=0, pending=0, pipe_stall=0.
  - rf_we=0, llu_ready=0, all hz_*=0.
  - Reset mid-forced-slot abandons the slot. The LLU must re-present its result.
- State NORMAL (pipe_stall=0):
  - pipe_we=1: rf_we=1, rf_a3=pipe_rd, rf_wd3=pipe_wd, llu_ready=0.
  - pipe_we=0 and llu_valid=1: LLU granted. rf_we=1 with llu_rd/llu_wd, llu_ready=1.
  - Grant path is combinational from inputs. The register file samples on the falling edge.
  - wait_cnt increments each cycle llu_valid=1 and llu_ready=0, and clears on any LLU handshake or when llu_valid=0.
  - If wait_cnt==MAX_WAIT-1 while still blocked: next state FORCE, pipe_stall<=1.
- State FORCE (pipe_stall=1):
  - pipe_we is ignored. The pipeline holds its writeback and re-presents it after the stall.
  - llu_ready=llu_valid, and rf_we carries the LLU write.
  - On handshake: next state NORMAL, pipe_stall<=0, wait_cnt<=0. Stall lasts exactly one cycle.
  - If llu_valid=0 in FORCE (protocol violation): return to NORMAL without a write.
- x0 writes:
  - rf_we is forced 0 when the selected rd==0.
  - The handshake still completes (llu_ready=1), so the winner's transaction is consumed.
- Scoreboard:
  - alloc_valid with alloc_rd!=0 sets pending[alloc_rd] on the rising edge.
  - An LLU handshake clears pending[llu_rd].
  - Set and clear of the same register in one cycle: set wins.
  - hz_rsX/hz_rd = pending[chk_*]. These are combinational, registered-state only, and always 0 for register 0.
- Latency:
  - Grant to register-file write: same cycle.
  - Scoreboard update visible on hz_* one cycle after alloc or handshake.

Optional Feature:
ARB_STATS_EN:
- Defined: adds output stat_force_cnt [15:0]. It increments on each NORMAL->FORCE transition, saturates at 16'hFFFF, and resets to 0.
- Undefined: no port and no counter logic. Behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - State encoding constants ST_NORMAL, ST_FORCE.
  - Register-zero constant REG_ZERO.
  - Default MAX_WAIT.
- One sub-module is natural: rf_scoreboard, which contains the pending vector, set/clear priority and the three hazard read ports.
- Arbitration FSM and write-port mux stay in the top level.

Test Plan:
- pipe_we=1 (rd=5, wd=0x11) with llu_valid=0 -> rf_we=1, rf_a3=5, rf_wd3=0x11, llu_ready=0, pipe_stall=0.
- pipe_we=0, llu_valid=1 (rd=9, wd=0xAB) -> same-cycle llu_ready=1, rf_a3=9, rf_wd3=0xAB. Setting pending[9] beforehand, it clears and hz_rs1 (chk_rs1=9) drops next cycle.
- Starvation with MAX_WAIT=4: pipe_we=1 continuously with llu_valid=1 (rd=4):
  - pipe_stall rises after the 4th blocked cycle.
  - In that stalled cycle rf_a3=4 and llu_ready=1.
  - pipe_stall falls the next cycle.
  - stat_force_cnt=1 if ARB_STATS_EN.
- alloc_valid (rd=7) and LLU handshake (rd=7) in the same cycle -> pending[7] stays 1, hz_rd=1 with chk_rd=7. alloc_rd=0 -> no hazard.
- LLU result to rd=0 -> llu_ready=1, rf_we=0.
- Reset asserted during FORCE -> pipe_stall, rf_we and llu_ready go 0 immediately, and all hz_*=0 after reset.
